// File: rtl/vec_seq_pkg.sv
// Shared types and default sizes for the exhaustive vector sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state enum, default NUM_PI / NUM_PO / SETTLE_W.
package vec_seq_pkg;

  localparam int DEF_NUM_PI   = 6;
  localparam int DEF_NUM_PO   = 5;
  localparam int DEF_SETTLE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/settle_counter.sv
// Settle timer: loads a cycle count, counts down to zero, flags zero.
// Latency: zero flag reflects the registered count (load visible next cycle).
// Backpressure: none; decrement is ignored once the count reaches zero.
// Ports: clk, rst_n (sync, active-low), load/load_val, dec, zero.
module settle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Exhaustive stimulus sweep of a combinational DUT against a golden table.
// Latency: S+4 cycles per vector; done pulses 2^NUM_PI*(S+4) cycles after start.
// Backpressure: none; start ignored while busy, abort forces IDLE.
// Ports: clk, rst_n, start, abort, settle_cycles in; pi, exp_addr out to DUT/table;
//        po, exp_data in; busy, done, pass, err_cnt, first_fail status out.
module vector_sequencer
  import vec_seq_pkg::*;
#(
  parameter int NUM_PI   = DEF_NUM_PI,
  parameter int NUM_PO   = DEF_NUM_PO,
  parameter int SETTLE_W = DEF_SETTLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [NUM_PI-1:0]   pi,
  input  logic [NUM_PO-1:0]   po,
  output logic [NUM_PI-1:0]   exp_addr,
  input  logic [NUM_PO-1:0]   exp_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [NUM_PI:0]     err_cnt,
  output logic [NUM_PI-1:0]   first_fail
);

  localparam logic [NUM_PI-1:0] VEC_LAST = '1;
  localparam logic [NUM_PI:0]   ERR_MAX  = {1'b1, {NUM_PI{1'b0}}};

  state_e              state_q, state_d;
  logic [NUM_PI-1:0]   vec_q, vec_d;
  logic [NUM_PI-1:0]   pi_q, pi_d;
  logic [SETTLE_W-1:0] s_q, s_d;
  logic [NUM_PI:0]     err_q, err_d;
  logic [NUM_PI-1:0]   ff_q, ff_d;
  logic                pass_q, pass_d;
  logic [NUM_PO-1:0]   po_s_q, po_s_d;
  logic [NUM_PO-1:0]   exp_s_q, exp_s_d;
  logic                cnt_load, cnt_dec, cnt_zero;

  settle_counter #(.W(SETTLE_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (s_q),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    pi_d     = pi_q;
    s_d      = s_q;
    err_d    = err_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    po_s_d   = po_s_q;
    exp_s_d  = exp_s_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start together with abort launches nothing
        if (start && !abort) begin
          s_d     = settle_cycles;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        pi_d     = vec_q;
        cnt_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        // counter was loaded with S, so this state spans S+1 cycles
        if (cnt_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        po_s_d  = po;
        exp_s_d = exp_data;
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (po_s_q != exp_s_q) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + (NUM_PI+1)'(1);
          end
          if (err_q == '0) begin
            ff_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + NUM_PI'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // abort wins over every in-flight update; error results are frozen
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      pass_d   = 1'b0;
      vec_d    = vec_q;
      pi_d     = pi_q;
      err_d    = err_q;
      ff_d     = ff_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      pi_q    <= '0;
      s_q     <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      po_s_q  <= '0;
      exp_s_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pi_q    <= pi_d;
      s_q     <= s_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      po_s_q  <= po_s_d;
      exp_s_q <= exp_s_d;
    end
  end

  // golden address always tracks the applied vector
  assign pi         = pi_q;
  assign exp_addr   = pi_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_vector_sequencer.sv
module tb_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] settle_cycles = 4'd0;
  logic [5:0] pi;
  logic [4:0] po;
  logic [5:0] exp_addr;
  logic [4:0] exp_data = 5'd0;
  logic       busy, done, pass;
  logic [6:0] err_cnt;
  logic [5:0] first_fail;

  logic [4:0] gold [64];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  vector_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .settle_cycles (settle_cycles),
    .pi            (pi),
    .po            (po),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_fail    (first_fail)
  );

  // combinational DUT being swept
  function automatic logic [4:0] dut_fn(input logic [5:0] x);
    return x[5:1] ^ {x[2:0], x[4:3]};
  endfunction

  assign po = dut_fn(pi);

  // golden table with one-cycle registered read
  always @(posedge clk) exp_data <= gold[exp_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gold_clean();
    for (int i = 0; i < 64; i++) gold[i] = dut_fn(6'(i));
  endtask

  // start a sweep and count edges from the start-accepting edge until done
  task automatic sweep(input logic [3:0] s, output int n);
    settle_cycles = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    settle_cycles = 4'd9;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_pi(input logic [5:0] target, output int n);
    n = 0;
    while (pi !== target && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, n1, n2, seen;

    gold_clean();

    // reset
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_pi", 32'(pi), 0);
    check("rst_exp_addr", 32'(exp_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_first_fail", 32'(first_fail), 0);
    rst_n = 1'b1;
    tick();

    // start together with abort in IDLE does nothing
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 0);
    tick();
    check("idle_abort_done", 32'(done), 0);

    // clean sweep, S=2: 64*6 = 384
    sweep(4'd2, n);
    check("clean_s2_cycles", 32'(n), 384);
    tick();
    check("clean_s2_done_pulse", 32'(done), 0);
    check("clean_s2_pass", 32'(pass), 1);
    check("clean_s2_err_cnt", 32'(err_cnt), 0);
    check("clean_s2_busy", 32'(busy), 0);

    // entry 3 off by one bit, S=0: 64*4 = 256
    gold[3] = dut_fn(6'd3) ^ 5'b00001;
    sweep(4'd0, n);
    check("bad3_cycles", 32'(n), 256);
    tick();
    check("bad3_err_cnt", 32'(err_cnt), 1);
    check("bad3_first_fail", 32'(first_fail), 3);
    check("bad3_pass", 32'(pass), 0);

    // entries 10 and 40 corrupted, S=1: 64*5 = 320
    gold_clean();
    gold[10] = ~dut_fn(6'd10);
    gold[40] = dut_fn(6'd40) ^ 5'b10000;
    sweep(4'd1, n);
    check("bad10_40_cycles", 32'(n), 320);
    tick();
    check("bad10_40_err_cnt", 32'(err_cnt), 2);
    check("bad10_40_first_fail", 32'(first_fail), 10);
    check("bad10_40_pass", 32'(pass), 0);

    // abort during vector 17 SETTLE, S=3; entry 10 still bad
    gold_clean();
    gold[10] = ~dut_fn(6'd10);
    settle_cycles = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pi(6'd17, n);
    check("abort_reach17", 32'(n), 17 * 7 + 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_pass", 32'(pass), 0);
    check("abort_err_hold", 32'(err_cnt), 1);
    check("abort_ff_hold", 32'(first_fail), 10);
    check("abort_pi_hold", 32'(pi), 17);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) seen++;
    end
    check("abort_stays_idle", 32'(seen), 0);

    // full clean sweep after abort
    gold_clean();
    sweep(4'd0, n);
    check("post_abort_cycles", 32'(n), 256);
    tick();
    check("post_abort_pass", 32'(pass), 1);
    check("post_abort_err_cnt", 32'(err_cnt), 0);

    // start pulses while busy are ignored, then reset during vector 30
    settle_cycles = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pi(6'd5, n1);
    check("busy_reach5", 32'(n1), 5 * 4 + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pi(6'd30, n2);
    check("busy_reach30", 32'(n1 + 1 + n2), 30 * 4 + 1);
    rst_n = 1'b0;
    tick();
    check("midrst_pi", 32'(pi), 0);
    check("midrst_exp_addr", 32'(exp_addr), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_pass", 32'(pass), 0);
    check("midrst_err_cnt", 32'(err_cnt), 0);
    check("midrst_first_fail", 32'(first_fail), 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done || busy) seen++;
    end
    check("midrst_no_resume", 32'(seen), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
